// File: rtl/sound_capture.sv
// sound_capture: rate-divided L/R audio capture into a FIFO, drained as fixed-size
// sample bursts over a valid/ready word stream (mono = L only, stereo = L then R).
module sound_capture #(
    parameter int AW   = 11,
    parameter int DIV0 = 1024,
    parameter int DIV1 = 2248,
    parameter int DIV2 = 1124
) (
    input  logic          clk_sys,
    input  logic          sound_reset,
    input  logic          sound_enabled,
    input  logic [1:0]    sound_rate,
    input  logic [1:0]    sound_chan,
    input  logic [15:0]   sound_l_in,
    input  logic [15:0]   sound_r_in,
    input  logic [11:0]   blk_samples,
    input  logic          tx_ready,
    output logic          tx_valid,
    output logic [15:0]   tx_data,
    output logic          tx_last,
    output logic [AW:0]   samples_avail,
    output logic [15:0]   samples_dropped,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND_L, SEND_R} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, div, dropped_q, dropped_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
    logic [11:0] rem_q, rem_d;
    logic [1:0]  chan_q, chan_d;
    logic        ovf_q, ovf_d;
    logic [31:0] hold_q;
    logic [31:0] mem [0:(1<<AW)-1];
    logic        strobe, capture, full, wr_en, rd_en, done;

    always_comb begin
        div       = sound_rate == 2'd1 ? 16'(DIV1) : sound_rate == 2'd2 ? 16'(DIV2) : 16'(DIV0);
        // >= rather than == so a smaller divider never has to wrap the counter
        strobe    = cnt_q >= div - 16'd1;
        cnt_d     = strobe ? 16'd0 : cnt_q + 16'd1;
        fill      = wr_ptr_q - rd_ptr_q;
        full      = fill[AW];
        capture   = strobe && sound_enabled && sound_chan != 2'd0;
        wr_en     = capture && !full;
        dropped_d = capture && full && dropped_q != 16'hFFFF ? dropped_q + 16'd1 : dropped_q;
        ovf_d     = ovf_q || (capture && full);
        wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
        state_d   = state_q;
        rem_d     = rem_q;
        chan_d    = chan_q;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: if (sound_chan != 2'd0 && blk_samples != 12'd0 && {20'd0, blk_samples} <= 32'(fill)) begin
                chan_d  = sound_chan;
                rem_d   = blk_samples;
                state_d = FETCH;
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = SEND_L;
            end
            SEND_L: if (tx_ready) begin
                state_d = chan_q >= 2'd2 ? SEND_R : state_q;
                done    = chan_q < 2'd2;
            end
            SEND_R: done = tx_ready;
            default: state_d = IDLE;
        endcase
        if (done) begin
            rem_d   = rem_q - 12'd1;
            state_d = rem_q == 12'd1 ? IDLE : FETCH;
        end
        rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_en);
    end

    always_ff @(posedge clk_sys) begin
        if (sound_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dropped_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            chan_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            chan_q    <= chan_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {sound_l_in, sound_r_in};
        if (rd_en) hold_q <= mem[rd_ptr_q[AW-1:0]];
    end

    assign tx_valid        = state_q == SEND_L || state_q == SEND_R;
    assign tx_data         = state_q == SEND_L ? hold_q[31:16] : state_q == SEND_R ? hold_q[15:0] : 16'd0;
    assign tx_last         = rem_q == 12'd1 && (state_q == SEND_R || (state_q == SEND_L && chan_q < 2'd2));
    assign samples_avail   = fill;
    assign samples_dropped = dropped_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_sound_capture.sv
// tb_sound_capture: directed bench for sound_capture (AW=3, DIV0=16); the sample
// fed at strobe n is base+n, so expected burst words follow from the bases.
module tb_sound_capture;
    logic        clk_sys = 1'b0;
    logic        sound_reset, sound_enabled, tx_ready, tx_valid, tx_last, overflow;
    logic [1:0]  sound_rate, sound_chan;
    logic [15:0] sound_l_in, sound_r_in, tx_data, samples_dropped;
    logic [11:0] blk_samples;
    logic [3:0]  samples_avail;
    logic [15:0] lbase, rbase;
    logic [15:0] got_d [64];
    logic        got_l [64];
    int          got_n, e, tests = 0, failed = 0;

    always #5 clk_sys = ~clk_sys;

    sound_capture #(.AW(3), .DIV0(16), .DIV1(20), .DIV2(12)) dut (
        .clk_sys(clk_sys), .sound_reset(sound_reset), .sound_enabled(sound_enabled),
        .sound_rate(sound_rate), .sound_chan(sound_chan), .sound_l_in(sound_l_in),
        .sound_r_in(sound_r_in), .blk_samples(blk_samples), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .samples_avail(samples_avail), .samples_dropped(samples_dropped), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        sound_l_in = lbase + 16'(e / 16);
        sound_r_in = rbase + 16'(e / 16);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        e++;
        drive();
    endtask

    task automatic run_to(input int t);
        while (e < t) tick();
    endtask

    task automatic rst_cycle();
        sound_reset = 1'b1;
        tick();
        tick();
        sound_reset = 1'b0;
        e = 0;
        drive();
    endtask

    task automatic collect(input int n, input bit slow);
        logic        pv = 1'b0, pr = 1'b0, plast = 1'b0;
        logic [15:0] pd = 16'd0;
        int          k = 0;
        got_n = 0;
        while (got_n < n && k < 400) begin
            tx_ready = slow ? (k % 3 == 2) : 1'b1;
            if (pv && !pr) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(pd));
                check("hold_last", 32'(tx_last), 32'(plast));
            end
            if (tx_valid && tx_ready) begin
                got_d[got_n] = tx_data;
                got_l[got_n] = tx_last;
                got_n++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; plast = tx_last;
            tick();
            k++;
        end
        tx_ready = 1'b1;
        check("word_count", 32'(got_n), 32'(n));
    endtask

    task automatic check_burst(input string tag, input logic [15:0] lb, input logic [15:0] rb,
                               input int ns, input bit st);
        int w = 0;
        for (int s = 0; s < ns; s++) begin
            check({tag, "_L"}, 32'(got_d[w]), 32'(lb + 16'(s)));
            check({tag, "_L_last"}, 32'(got_l[w]), 32'(!st && s == ns - 1));
            w++;
            if (st) begin
                check({tag, "_R"}, 32'(got_d[w]), 32'(rb + 16'(s)));
                check({tag, "_R_last"}, 32'(got_l[w]), 32'(s == ns - 1));
                w++;
            end
        end
    endtask

    initial begin
        sound_enabled = 1'b1; sound_rate = 2'd0; sound_chan = 2'd1; blk_samples = 12'd4;
        tx_ready = 1'b1; lbase = 16'h1000; rbase = 16'h2000; e = 0; drive();
        rst_cycle();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_avail", 32'(samples_avail), 32'd0);
        check("rst_dropped", 32'(samples_dropped), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        run_to(15);
        check("strobe_pre", 32'(samples_avail), 32'd0);
        tick();
        check("strobe_first", 32'(samples_avail), 32'd1);
        run_to(65);
        check("lat_pre", 32'(tx_valid), 32'd0);
        tick();
        check("lat_valid", 32'(tx_valid), 32'd1);
        collect(4, 1'b0);
        check_burst("mono", 16'h1000, 16'h2000, 4, 1'b0);
        check("mono_avail", 32'(samples_avail), 32'd0);
        check("mono_idle", 32'(tx_valid), 32'd0);

        sound_chan = 2'd2; blk_samples = 12'd2; lbase = 16'hA000; rbase = 16'hB000;
        rst_cycle();
        collect(4, 1'b0);
        check_burst("stereo", 16'hA000, 16'hB000, 2, 1'b1);

        blk_samples = 12'd3; lbase = 16'h3000; rbase = 16'h4000;
        rst_cycle();
        collect(6, 1'b1);
        check_burst("bp", 16'h3000, 16'h4000, 3, 1'b1);
        check("bp_idle", 32'(tx_valid), 32'd0);

        blk_samples = 12'd0; tx_ready = 1'b0; lbase = 16'h5000; rbase = 16'h6000;
        rst_cycle();
        run_to(160);
        check("ovf_avail", 32'(samples_avail), 32'd8);
        check("ovf_dropped", 32'(samples_dropped), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_idle", 32'(tx_valid), 32'd0);
        blk_samples = 12'd8;
        collect(16, 1'b0);
        check_burst("drain", 16'h5000, 16'h6000, 8, 1'b1);
        check("drain_dropped", 32'(samples_dropped), 32'd2);

        blk_samples = 12'd2; lbase = 16'hA000; rbase = 16'hB000;
        rst_cycle();
        check("rst_ovf_clear", 32'(overflow), 32'd0);
        run_to(35);
        check("midrst_sendr", 32'(tx_valid), 32'd1);
        check("midrst_rdata", 32'(tx_data), 32'hB000);
        sound_reset = 1'b1;
        tick();
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_last", 32'(tx_last), 32'd0);
        check("midrst_avail", 32'(samples_avail), 32'd0);
        sound_reset = 1'b0; e = 0; drive();
        run_to(15);
        check("resume_pre", 32'(samples_avail), 32'd0);
        tick();
        check("resume_first", 32'(samples_avail), 32'd1);

        lbase = 16'h7000; rbase = 16'h8000;
        rst_cycle();
        run_to(34);
        sound_chan = 2'd1;
        collect(4, 1'b0);
        check_burst("chg_cur", 16'h7000, 16'h8000, 2, 1'b1);
        collect(2, 1'b0);
        check_burst("chg_next", 16'h7002, 16'h8002, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
